// File: rtl/pipe_mux_n.sv
// N-lane select mux with a registered ready/valid output and a two-entry
// (main + skid) buffer, so in_ready never depends combinationally on out_ready.
module pipe_mux_n #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_err_q, main_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q, in_ready_d;

  logic             main_valid;
  logic             skid_valid;
  logic             acc;
  logic             drn;
  logic [WIDTH:0]   beat;

  // Returns {err, lane}; codes at or above N_IN fall back to lane 0 with err set.
  function automatic logic [WIDTH:0] pick_lane(input logic [N_IN*WIDTH-1:0] d,
                                               input logic [SEL_W-1:0]      s);
    logic [WIDTH:0] r;
    r = {1'b1, d[WIDTH-1:0]};
    for (int k = 0; k < N_IN; k++) begin
      if (s == SEL_W'(k)) r = {1'b0, d[k*WIDTH +: WIDTH]};
    end
    return r;
  endfunction

  // Entry valid bits are encoded by the occupancy state.
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  assign acc  = in_valid && in_ready_q;
  assign drn  = main_valid && out_ready;
  assign beat = pick_lane(in_data, in_sel);

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          main_data_d = beat[WIDTH-1:0];
          main_err_d  = beat[WIDTH];
          state_d     = ONE;
        end
      end
      ONE: begin
        if (acc && drn) begin
          main_data_d = beat[WIDTH-1:0];
          main_err_d  = beat[WIDTH];
        end else if (acc) begin
          skid_data_d = beat[WIDTH-1:0];
          skid_err_d  = beat[WIDTH];
          state_d     = FULL;
        end else if (drn) begin
          state_d     = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (drn) begin
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Skid payload is only meaningful while FULL, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    skid_err_q  <= skid_err_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid;
  assign out_data    = main_data_q;
  assign out_sel_err = main_err_q;

  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed-vector and scoreboard bench for pipe_mux_n (default and N_IN=3 builds).
module tb_pipe_mux_n;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_sel_err;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  d3_in_data;
  logic [1:0]   d3_in_sel;
  logic         d3_in_valid;
  logic         d3_in_ready;
  logic [31:0]  d3_out_data;
  logic         d3_out_sel_err;
  logic         d3_out_valid;
  logic         d3_out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_mux_n #(.WIDTH(32), .N_IN(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel_err(out_sel_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  pipe_mux_n #(.WIDTH(32), .N_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(d3_in_data), .in_sel(d3_in_sel),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_sel_err(d3_out_sel_err), .out_valid(d3_out_valid), .out_ready(d3_out_ready)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic        ordy;
    logic        ov;
    logic        chk_data;
    logic [31:0] data;
    logic        err;
    logic        irdy;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_val(input int k);
    return 32'h11111111 * (k + 1);
  endfunction

  logic [31:0] q[$];
  logic [31:0] held;
  logic        stall_prev;
  int          beats_in;
  int          cyc;
  logic        feed;

  initial begin
    // in_valid, sel, out_ready | out_valid, check data?, data, err, in_ready
    vecs[0] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h33333333, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[2] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h22222222, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h33333333, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[8] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 32'h44444444, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};

    rst          = 1'b1;
    in_data      = {lane_val(3), lane_val(2), lane_val(1), lane_val(0)};
    in_sel       = 2'd0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    d3_in_data   = {32'hCCCC0000, 32'hBBBB0000, 32'hAAAA0000};
    d3_in_sel    = 2'd0;
    d3_in_valid  = 1'b0;
    d3_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, 32'h0);
    check("rst_sel_err", out_sel_err, 1'b0);
    check("rst3_out_valid", d3_out_valid, 1'b0);

    // Table-driven directed vectors: basic select, skid fill/drain, order.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      in_valid  = vecs[i].iv;
      in_sel    = vecs[i].sel;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].irdy);
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_out_data", i), out_data, vecs[i].data);
        check($sformatf("vec%0d_sel_err", i), out_sel_err, vecs[i].err);
      end
    end

    // N_IN=3: code 3 is out of range -> lane 0 with error flag.
    @(negedge clk);
    in_valid    = 1'b0;
    d3_in_valid = 1'b1;
    d3_in_sel   = 2'd3;
    @(posedge clk);
    #1;
    check("n3_oor_valid", d3_out_valid, 1'b1);
    check("n3_oor_data", d3_out_data, 32'hAAAA0000);
    check("n3_oor_err", d3_out_sel_err, 1'b1);
    @(negedge clk);
    d3_in_sel = 2'd2;
    @(posedge clk);
    #1;
    check("n3_lane2_data", d3_out_data, 32'hCCCC0000);
    check("n3_lane2_err", d3_out_sel_err, 1'b0);
    @(negedge clk);
    d3_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("n3_idle_valid", d3_out_valid, 1'b0);

    // Fill to FULL, then reset with in_valid held high.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    @(posedge clk);
    @(negedge clk);
    in_sel = 2'd1;
    @(posedge clk);
    #1;
    check("full_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst    = 1'b1;
    in_sel = 2'd2;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_sel_err", out_sel_err, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("postrst%0d_no_stale", i), out_valid, 1'b0);
    end

    // Streaming: one beat per cycle, 1-cycle latency.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_sel    = 2'(i % 4);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d_valid", i), out_valid, 1'b1);
      check($sformatf("stream%0d_ready", i), in_ready, 1'b1);
      check($sformatf("stream%0d_data", i), out_data, lane_val(i % 4));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream_end_valid", out_valid, 1'b0);

    // Random in_valid/out_ready with a scoreboard.
    beats_in   = 0;
    cyc        = 0;
    stall_prev = 1'b0;
    held       = '0;
    while ((beats_in < 10000 || q.size() > 0 || out_valid) && cyc < 60000) begin
      @(negedge clk);
      feed      = (beats_in < 10000);
      in_valid  = feed ? 1'($urandom_range(0, 1)) : 1'b0;
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = feed ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall_prev) begin
        check("rand_stall_valid", out_valid, 1'b1);
        check("rand_stall_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rand_extra: actual=0x%0h required=no beat at %0t", out_data, $time);
        end else begin
          check("rand_data", out_data, q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data[in_sel*32 +: 32]);
        beats_in++;
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      cyc++;
    end
    check("rand_beats_in", beats_in, 10000);
    check("rand_lost", q.size(), 0);
    check("rand_idle", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
PIPE_MUX_N -- requirements
Module: pipe_mux_n

Parameters
REQ-001 WIDTH, default 32, bit width of each data lane.
REQ-002 N_IN, default 4, number of input lanes (2..16).
REQ-003 SEL_W, default 2, select width; SHALL satisfy 2^SEL_W >= N_IN.

Interface
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  N_IN*WIDTH  packed lanes; lane k = bits [k*WIDTH +: WIDTH].
REQ-007 in_sel  input  SEL_W  lane select, qualified by in_valid.
REQ-008 in_valid  input  1  upstream beat valid.
REQ-009 in_ready  output  1  block can accept a beat this cycle.
REQ-010 out_data  output  WIDTH  selected lane, registered.
REQ-011 out_sel_err  output  1  beat was issued with in_sel >= N_IN; travels with out_data.
REQ-012 out_valid  output  1  out_data/out_sel_err valid.
REQ-013 out_ready  input  1  downstream accepts beat.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready.
REQ-015 Lane selection: in_sel < N_IN -> lane in_sel; in_sel >= N_IN -> lane 0 with out_sel_err=1 for that beat.
REQ-016 Storage SHALL be two entries: main (drives outputs) and skid; each holds data, err bit, valid bit.
REQ-017 in_ready SHALL be a registered signal equal to !skid_valid; never a combinational function of out_ready.
REQ-018 Latency SHALL be exactly 1 cycle: beat accepted at edge t appears on outputs after edge t when main is empty or being drained.
REQ-019 Main empty, or main valid and out_ready: accepted beat loads main; skid unchanged.
REQ-020 Main valid, out_ready=0, input transfer: beat loads skid; in_ready deasserts next cycle.
REQ-021 Skid valid and out_ready=1: skid moves to main, skid cleared; in_ready reasserts next cycle.
REQ-022 States {EMPTY, ONE, FULL} = count of valid entries 0/1/2; EMPTY->ONE on accept; ONE->FULL on accept w/o drain; ONE->EMPTY on drain w/o accept; ONE->ONE on simultaneous accept+drain; FULL->ONE on drain (no accept possible in FULL).
REQ-023 Beats SHALL leave in acceptance order; no beat dropped or duplicated.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_sel_err SHALL remain stable.
REQ-025 Input data/sel with in_valid=0 or in_ready=0 SHALL be ignored.
REQ-026 N_IN not a power of two: unused select codes are out of range per REQ-015.

Reset
REQ-027 rst=1 at an edge: out_valid=0, skid empty, in_ready=1, out_data=0, out_sel_err=0, state EMPTY.
REQ-028 Reset mid-operation SHALL discard both stored beats; an input asserted in the reset cycle is not accepted.
REQ-029 First transfer possible at the first edge with rst=0.

Verification
REQ-030 Default params, lanes {0x11111111,0x22222222,0x33333333,0x44444444}, sel=2, in_valid pulse, out_ready=1 -> next cycle out_data=0x33333333, out_valid=1, out_sel_err=0; then out_valid=0.
REQ-031 N_IN=3, SEL_W=2, sel=3, lane0=0xAAAA0000 -> out_data=0xAAAA0000, out_sel_err=1.
REQ-032 out_ready=0, three back-to-back beats (sel 0,1,2) -> first two held (main=lane0, skid=lane1), in_ready=0 after second accept, third not accepted; raise out_ready -> lanes 0,1, then third after re-accept, order preserved.
REQ-033 Continuous in_valid=1, out_ready=1, sel cycling 0..3 for 16 cycles -> one beat out per cycle, in_ready constantly 1, out sequence equals input sequence delayed 1 cycle.
REQ-034 FULL state, rst=1 for one cycle -> out_valid=0, in_ready=1, out_data=0 next cycle; no stale beat appears after reset release.
REQ-035 Random in_valid/out_ready (50% each), 10k beats, scoreboard -> zero mismatches, zero losses, out_data stable while stalled.
